// File: rtl/pic_bus_master.sv
// Bus master for an 8259-style interrupt controller: ICW init sequences, OCW writes
// and IRR/ISR/IMR reads, run as a short list of strobed bus cycles.
module pic_bus_master #(
    parameter int WR_WIDTH = 2,
    parameter int RD_WIDTH = 2,
    parameter int RECOVERY = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       init_start,
    input  logic [7:0] icw1,
    input  logic [7:0] icw2,
    input  logic [7:0] icw3,
    input  logic [7:0] icw4,
    input  logic       ocw_req,
    input  logic [1:0] ocw_sel,
    input  logic [7:0] ocw_data,
    input  logic       rd_req,
    input  logic [1:0] rd_sel,
    output logic       CS_n,
    output logic       WR_n,
    output logic       RD_n,
    output logic       A0,
    output logic [7:0] cpu_data_out,
    output logic       cpu_data_oe,
    input  logic [7:0] cpu_data_in,
    output logic       busy,
    output logic       initialized,
    output logic       init_done,
    output logic       ocw_done,
    output logic       rd_valid,
    output logic       err,
    output logic [7:0] rd_data
);

    typedef enum logic [2:0] {
        IDLE, W_SETUP, W_STROBE, W_HOLD, R_SETUP, R_STROBE, R_HOLD, RECOVER
    } state_t;

    typedef enum logic [1:0] {K_INIT, K_OCW, K_READ} kind_t;

    state_t          state_r, state_s;
    kind_t           kind_r, kind_s;
    logic [7:0]      cnt_r, cnt_s;
    logic [1:0]      idx_r, idx_s;
    logic [1:0]      last_r, last_s;
    logic [3:0][7:0] op_data_r, op_data_s;
    logic [3:0]      op_a0_r, op_a0_s;
    logic [3:0]      op_rd_r, op_rd_s;
    logic            initialized_s;
    logic            cap_s;
    logic            init_done_s, ocw_done_s, rd_valid_s, err_s;
    logic            cs_n_s, wr_n_s, rd_n_s, oe_s, a0_s;
    logic [7:0]      dout_s;

    // Next-state, operation-list loading and pulse generation
    always_comb begin
        state_s       = state_r;
        kind_s        = kind_r;
        cnt_s         = cnt_r;
        idx_s         = idx_r;
        last_s        = last_r;
        op_data_s     = op_data_r;
        op_a0_s       = op_a0_r;
        op_rd_s       = op_rd_r;
        initialized_s = initialized;
        cap_s         = 1'b0;
        init_done_s   = 1'b0;
        ocw_done_s    = 1'b0;
        rd_valid_s    = 1'b0;
        err_s         = 1'b0;

        case (state_r)
            IDLE: begin
                idx_s = 2'd0;
                if (init_start) begin
                    // ICW3 and ICW4 are optional; slot 2 holds whichever comes first.
                    op_data_s     = {icw4, (icw1[1] ? icw4 : icw3), icw2, (icw1 | 8'h10)};
                    op_a0_s       = 4'b1110;
                    op_rd_s       = 4'b0000;
                    last_s        = 2'd1 + {1'b0, ~icw1[1]} + {1'b0, icw1[0]};
                    kind_s        = K_INIT;
                    initialized_s = 1'b0;
                    state_s       = W_SETUP;
                end else if (ocw_req) begin
                    if (!initialized || ocw_sel == 2'b11) begin
                        err_s = 1'b1;
                    end else begin
                        case (ocw_sel)
                            2'b00:   op_data_s[0] = ocw_data;
                            2'b01:   op_data_s[0] = ocw_data & 8'hE7;
                            default: op_data_s[0] = (ocw_data & 8'hE7) | 8'h08;
                        endcase
                        op_a0_s = {3'b000, (ocw_sel == 2'b00)};
                        op_rd_s = 4'b0000;
                        last_s  = 2'd0;
                        kind_s  = K_OCW;
                        state_s = W_SETUP;
                    end
                end else if (rd_req) begin
                    if (!initialized || rd_sel == 2'b11) begin
                        err_s = 1'b1;
                    end else if (rd_sel == 2'b10) begin
                        op_data_s = {8'h00, 8'h00, 8'h00, 8'h00};
                        op_a0_s   = 4'b0001;
                        op_rd_s   = 4'b0001;
                        last_s    = 2'd0;
                        kind_s    = K_READ;
                        state_s   = R_SETUP;
                    end else begin
                        // OCW3 read-register select, then the read itself
                        op_data_s = {8'h00, 8'h00, 8'h00, (rd_sel[0] ? 8'h0B : 8'h0A)};
                        op_a0_s   = 4'b0000;
                        op_rd_s   = 4'b0010;
                        last_s    = 2'd1;
                        kind_s    = K_READ;
                        state_s   = W_SETUP;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            W_SETUP: begin
                cnt_s   = 8'(WR_WIDTH - 1);
                state_s = W_STROBE;
            end
            W_STROBE: begin
                if (cnt_r == 8'd0) begin
                    state_s = W_HOLD;
                end else begin
                    cnt_s = cnt_r - 8'd1;
                end
            end
            W_HOLD: begin
                cnt_s   = 8'(RECOVERY - 1);
                state_s = RECOVER;
            end
            R_SETUP: begin
                cnt_s   = 8'(RD_WIDTH - 1);
                state_s = R_STROBE;
            end
            R_STROBE: begin
                if (cnt_r == 8'd0) begin
                    cap_s   = 1'b1;
                    state_s = R_HOLD;
                end else begin
                    cnt_s = cnt_r - 8'd1;
                end
            end
            R_HOLD: begin
                cnt_s   = 8'(RECOVERY - 1);
                state_s = RECOVER;
            end
            RECOVER: begin
                if (cnt_r != 8'd0) begin
                    cnt_s = cnt_r - 8'd1;
                end else if (idx_r == last_r) begin
                    state_s = IDLE;
                    case (kind_r)
                        K_INIT: begin
                            init_done_s   = 1'b1;
                            initialized_s = 1'b1;
                        end
                        K_OCW:   ocw_done_s = 1'b1;
                        K_READ:  rd_valid_s = 1'b1;
                        default: err_s      = 1'b0;
                    endcase
                end else begin
                    idx_s   = idx_r + 2'd1;
                    state_s = op_rd_r[idx_s] ? R_SETUP : W_SETUP;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Bus pin values for the upcoming state, so the pins change with the state register
    always_comb begin
        cs_n_s = 1'b1;
        wr_n_s = 1'b1;
        rd_n_s = 1'b1;
        oe_s   = 1'b0;
        a0_s   = 1'b0;
        dout_s = 8'h00;
        case (state_s)
            W_SETUP, W_STROBE, W_HOLD: begin
                cs_n_s = 1'b0;
                oe_s   = 1'b1;
                a0_s   = op_a0_s[idx_s];
                dout_s = op_data_s[idx_s];
                wr_n_s = (state_s != W_STROBE);
            end
            R_SETUP, R_STROBE, R_HOLD: begin
                cs_n_s = 1'b0;
                a0_s   = op_a0_s[idx_s];
                rd_n_s = (state_s != R_STROBE);
            end
            default: cs_n_s = 1'b1;
        endcase
    end

    // State, operation list and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            kind_r       <= K_INIT;
            cnt_r        <= 8'd0;
            idx_r        <= 2'd0;
            last_r       <= 2'd0;
            op_data_r    <= {8'h00, 8'h00, 8'h00, 8'h00};
            op_a0_r      <= 4'b0000;
            op_rd_r      <= 4'b0000;
            CS_n         <= 1'b1;
            WR_n         <= 1'b1;
            RD_n         <= 1'b1;
            A0           <= 1'b0;
            cpu_data_out <= 8'h00;
            cpu_data_oe  <= 1'b0;
            busy         <= 1'b0;
            initialized  <= 1'b0;
            init_done    <= 1'b0;
            ocw_done     <= 1'b0;
            rd_valid     <= 1'b0;
            err          <= 1'b0;
            rd_data      <= 8'h00;
        end else begin
            state_r      <= state_s;
            kind_r       <= kind_s;
            cnt_r        <= cnt_s;
            idx_r        <= idx_s;
            last_r       <= last_s;
            op_data_r    <= op_data_s;
            op_a0_r      <= op_a0_s;
            op_rd_r      <= op_rd_s;
            CS_n         <= cs_n_s;
            WR_n         <= wr_n_s;
            RD_n         <= rd_n_s;
            A0           <= a0_s;
            cpu_data_out <= dout_s;
            cpu_data_oe  <= oe_s;
            busy         <= (state_s != IDLE);
            initialized  <= initialized_s;
            init_done    <= init_done_s;
            ocw_done     <= ocw_done_s;
            rd_valid     <= rd_valid_s;
            err          <= err_s;
            rd_data      <= cap_s ? cpu_data_in : rd_data;
        end
    end

endmodule

// File: tb/tb_pic_bus_master.sv
// Bench for pic_bus_master: a waveform-level model built from the bus-cycle rules,
// compared every clock, plus hand-computed checks of write/read logs and latency.
module tb_pic_bus_master;
    localparam int WRW = 2;
    localparam int RDW = 2;
    localparam int REC = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, init_start, ocw_req, rd_req;
    logic [7:0] icw1, icw2, icw3, icw4, ocw_data, cpu_data_in, cpu_data_out, rd_data;
    logic [1:0] ocw_sel, rd_sel;
    logic CS_n, WR_n, RD_n, A0, cpu_data_oe, busy, initialized;
    logic init_done, ocw_done, rd_valid, err;
    logic [7:0] bus_val;

    // PIC drives its register only while RD_n is low
    assign cpu_data_in = RD_n ? 8'hFF : bus_val;

    pic_bus_master #(.WR_WIDTH(WRW), .RD_WIDTH(RDW), .RECOVERY(REC)) dut (
        .clk(clk), .rst(rst), .init_start(init_start),
        .icw1(icw1), .icw2(icw2), .icw3(icw3), .icw4(icw4),
        .ocw_req(ocw_req), .ocw_sel(ocw_sel), .ocw_data(ocw_data),
        .rd_req(rd_req), .rd_sel(rd_sel),
        .CS_n(CS_n), .WR_n(WR_n), .RD_n(RD_n), .A0(A0),
        .cpu_data_out(cpu_data_out), .cpu_data_oe(cpu_data_oe), .cpu_data_in(cpu_data_in),
        .busy(busy), .initialized(initialized),
        .init_done(init_done), .ocw_done(ocw_done), .rd_valid(rd_valid), .err(err),
        .rd_data(rd_data)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected per-cycle picture of the outputs
    typedef struct {
        logic cs_n, wr_n, rd_n, oe, a0;
        logic [7:0] data;
        logic busy, idn, odn, rv, er, set_init, last_strobe;
    } exp_t;

    exp_t q[$];
    logic [15:0] wr_log[$];
    logic [15:0] rd_log[$];
    int n_idn = 0, n_odn = 0, n_rv = 0, n_err = 0, done_cyc = 0;
    logic model_init = 1'b0;
    logic [7:0] exp_rd = 8'h00;

    function automatic exp_t idle_e();
        exp_t e;
        e.cs_n = 1'b1; e.wr_n = 1'b1; e.rd_n = 1'b1; e.oe = 1'b0; e.a0 = 1'b0;
        e.data = 8'h00; e.busy = 1'b0; e.idn = 1'b0; e.odn = 1'b0; e.rv = 1'b0;
        e.er = 1'b0; e.set_init = 1'b0; e.last_strobe = 1'b0;
        return e;
    endfunction

    task automatic push_recover();
        exp_t e;
        e = idle_e();
        e.busy = 1'b1;
        for (int i = 0; i < REC; i++) q.push_back(e);
    endtask

    task automatic push_write(input logic a0, input logic [7:0] d);
        exp_t e;
        e = idle_e();
        e.busy = 1'b1; e.cs_n = 1'b0; e.oe = 1'b1; e.a0 = a0; e.data = d;
        q.push_back(e);
        e.wr_n = 1'b0;
        for (int i = 0; i < WRW; i++) q.push_back(e);
        e.wr_n = 1'b1;
        q.push_back(e);
        push_recover();
    endtask

    task automatic push_read(input logic a0);
        exp_t e;
        e = idle_e();
        e.busy = 1'b1; e.cs_n = 1'b0; e.a0 = a0;
        q.push_back(e);
        e.rd_n = 1'b0;
        for (int i = 0; i < RDW; i++) begin
            e.last_strobe = (i == RDW - 1);
            q.push_back(e);
        end
        e.rd_n = 1'b1; e.last_strobe = 1'b0;
        q.push_back(e);
        push_recover();
    endtask

    // kind: 0 init, 1 ocw, 2 read, 3 error
    task automatic push_done(input int kind);
        exp_t e;
        e = idle_e();
        case (kind)
            0: begin e.idn = 1'b1; e.set_init = 1'b1; end
            1: e.odn = 1'b1;
            2: e.rv = 1'b1;
            default: e.er = 1'b1;
        endcase
        q.push_back(e);
    endtask

    task automatic model_accept();
        if (init_start) begin
            model_init = 1'b0;
            push_write(1'b0, icw1 | 8'h10);
            push_write(1'b1, icw2);
            if (!icw1[1]) push_write(1'b1, icw3);
            if (icw1[0]) push_write(1'b1, icw4);
            push_done(0);
        end else if (ocw_req) begin
            if (!model_init || ocw_sel == 2'b11) push_done(3);
            else begin
                if (ocw_sel == 2'b00) push_write(1'b1, ocw_data);
                else if (ocw_sel == 2'b01) push_write(1'b0, {ocw_data[7:5], 2'b00, ocw_data[2:0]});
                else push_write(1'b0, {ocw_data[7:5], 2'b01, ocw_data[2:0]});
                push_done(1);
            end
        end else if (rd_req) begin
            if (!model_init || rd_sel == 2'b11) push_done(3);
            else begin
                if (rd_sel == 2'b10) push_read(1'b1);
                else begin
                    push_write(1'b0, (rd_sel == 2'b00) ? 8'h0A : 8'h0B);
                    push_read(1'b0);
                end
                push_done(2);
            end
        end
    endtask

    // Model step and per-cycle comparison, plus bus-transaction logging
    initial begin : compare
        exp_t e;
        logic armed, pending, s_rst, prev_wr, prev_rd;
        logic [7:0] s_bus;
        armed = 1'b0; pending = 1'b0; prev_wr = 1'b1; prev_rd = 1'b1;
        forever begin
            @(posedge clk);
            s_rst = rst;
            s_bus = bus_val;
            #1;
            if (s_rst) armed = 1'b1;
            if (armed) begin
                if (s_rst) begin
                    q.delete();
                    model_init = 1'b0; exp_rd = 8'h00; pending = 1'b0;
                    e = idle_e();
                end else begin
                    if (pending) begin exp_rd = s_bus; pending = 1'b0; end
                    if (q.size() == 0) model_accept();
                    if (q.size() != 0) e = q.pop_front();
                    else e = idle_e();
                    if (e.last_strobe) pending = 1'b1;
                    if (e.set_init) model_init = 1'b1;
                end
                chk("cyc_cs_n", {15'd0, CS_n}, {15'd0, e.cs_n});
                chk("cyc_wr_n", {15'd0, WR_n}, {15'd0, e.wr_n});
                chk("cyc_rd_n", {15'd0, RD_n}, {15'd0, e.rd_n});
                chk("cyc_oe", {15'd0, cpu_data_oe}, {15'd0, e.oe});
                if (!e.cs_n || s_rst) chk("cyc_a0", {15'd0, A0}, {15'd0, e.a0});
                if (e.oe || s_rst) chk("cyc_data", {8'd0, cpu_data_out}, {8'd0, e.data});
                chk("cyc_busy", {15'd0, busy}, {15'd0, e.busy});
                chk("cyc_init_done", {15'd0, init_done}, {15'd0, e.idn});
                chk("cyc_ocw_done", {15'd0, ocw_done}, {15'd0, e.odn});
                chk("cyc_rd_valid", {15'd0, rd_valid}, {15'd0, e.rv});
                chk("cyc_err", {15'd0, err}, {15'd0, e.er});
                chk("cyc_initialized", {15'd0, initialized}, {15'd0, model_init});
                chk("cyc_rd_data", {8'd0, rd_data}, {8'd0, exp_rd});
                if (prev_wr && !WR_n) wr_log.push_back({7'd0, A0, cpu_data_out});
                if (prev_rd && !RD_n) rd_log.push_back({15'd0, A0});
                prev_wr = WR_n; prev_rd = RD_n;
                if (init_done) begin n_idn++; done_cyc = cyc; end
                if (ocw_done) n_odn++;
                if (rd_valid) n_rv++;
                if (err) n_err++;
            end
        end
    end

    function automatic logic [15:0] wlog(input int i);
        return (i < wr_log.size()) ? wr_log[i] : 16'hDEAD;
    endfunction

    task automatic clear_logs();
        wr_log.delete();
        rd_log.delete();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk("wait_idle_timeout", 16'(n), 16'd0);
        @(negedge clk);
    endtask

    int acc;
    task automatic do_init(input logic [7:0] a, b, c, d);
        clear_logs();
        @(negedge clk);
        icw1 = a; icw2 = b; icw3 = c; icw4 = d; init_start = 1'b1;
        acc = cyc + 1;
        @(negedge clk);
        init_start = 1'b0;
        chk("init_clears_initialized", {15'd0, initialized}, 16'd0);
        wait_idle();
    endtask

    task automatic req(input logic o, input logic r, input logic [1:0] osel,
                       input logic [7:0] od, input logic [1:0] rsel);
        clear_logs();
        @(negedge clk);
        ocw_req = o; rd_req = r; ocw_sel = osel; ocw_data = od; rd_sel = rsel;
        @(negedge clk);
        ocw_req = 1'b0; rd_req = 1'b0;
        wait_idle();
    endtask

    int base;
    initial begin : main
        rst = 1'b1; init_start = 1'b0; ocw_req = 1'b0; rd_req = 1'b0;
        icw1 = 8'h00; icw2 = 8'h00; icw3 = 8'h00; icw4 = 8'h00;
        ocw_sel = 2'b00; ocw_data = 8'h00; rd_sel = 2'b00; bus_val = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_cs_n", {15'd0, CS_n}, 16'd1);
        chk("rst_wr_rd_n", {14'd0, WR_n, RD_n}, 16'd3);
        chk("rst_busy_init", {14'd0, busy, initialized}, 16'd0);
        chk("rst_rd_data", {8'd0, rd_data}, 16'd0);
        rst = 1'b0;

        // Requests before initialization: error pulse, no bus activity
        base = n_err;
        req(1'b1, 1'b0, 2'b00, 8'h12, 2'b00);
        chk("ocw_pre_init_err", 16'(n_err - base), 16'd1);
        chk("ocw_pre_init_writes", 16'(wr_log.size()), 16'd0);
        req(1'b0, 1'b1, 2'b00, 8'h00, 2'b00);
        chk("rd_pre_init_err", 16'(n_err - base), 16'd2);

        // ICW4 needed, single mode: no ICW3
        base = n_idn;
        do_init(8'h13, 8'h20, 8'h77, 8'h01);
        chk("init1_nwrites", 16'(wr_log.size()), 16'd3);
        chk("init1_w0", wlog(0), 16'h013);
        chk("init1_w1", wlog(1), 16'h120);
        chk("init1_w2", wlog(2), 16'h101);
        chk("init1_latency", 16'(done_cyc - acc), 16'd18);
        chk("init1_done_cnt", 16'(n_idn - base), 16'd1);
        chk("init1_initialized", {15'd0, initialized}, 16'd1);

        // IRR read through OCW3 0x0A
        bus_val = 8'h5A;
        req(1'b0, 1'b1, 2'b00, 8'h00, 2'b00);
        chk("irr_write", wlog(0), 16'h00A);
        chk("irr_rd_a0", (rd_log.size() == 1) ? rd_log[0] : 16'hDEAD, 16'd0);
        chk("irr_rd_data", {8'd0, rd_data}, 16'h5A);
        bus_val = 8'hC3;
        req(1'b0, 1'b1, 2'b00, 8'h00, 2'b01);
        chk("isr_write", wlog(0), 16'h00B);
        chk("isr_rd_data", {8'd0, rd_data}, 16'hC3);
        bus_val = 8'h3C;
        req(1'b0, 1'b1, 2'b00, 8'h00, 2'b10);
        chk("imr_nwrites", 16'(wr_log.size()), 16'd0);
        chk("imr_rd_a0", (rd_log.size() == 1) ? rd_log[0] : 16'hDEAD, 16'd1);
        chk("imr_rd_data", {8'd0, rd_data}, 16'h3C);

        // OCW writes with address and forced bits
        req(1'b1, 1'b0, 2'b00, 8'hF0, 2'b00);
        chk("ocw1", wlog(0), 16'h1F0);
        req(1'b1, 1'b0, 2'b01, 8'hFF, 2'b00);
        chk("ocw2", wlog(0), 16'h0E7);
        req(1'b1, 1'b0, 2'b10, 8'h00, 2'b00);
        chk("ocw3", wlog(0), 16'h008);

        // Reserved selects
        base = n_err;
        req(1'b1, 1'b0, 2'b11, 8'h00, 2'b00);
        req(1'b0, 1'b1, 2'b00, 8'h00, 2'b11);
        chk("reserved_sel_err", 16'(n_err - base), 16'd2);

        // Simultaneous ocw_req and rd_req: only the OCW runs
        base = n_rv;
        req(1'b1, 1'b1, 2'b00, 8'hA5, 2'b10);
        chk("prio_writes", 16'(wr_log.size()), 16'd1);
        chk("prio_w0", wlog(0), 16'h1A5);
        chk("prio_no_read", 16'(rd_log.size() + n_rv - base), 16'd0);

        // Request while busy is dropped
        base = n_odn;
        clear_logs();
        @(negedge clk); ocw_req = 1'b1; ocw_sel = 2'b00; ocw_data = 8'h55;
        @(negedge clk); ocw_req = 1'b0;
        @(negedge clk); ocw_req = 1'b1; ocw_data = 8'h66;
        @(negedge clk); ocw_req = 1'b0;
        wait_idle();
        chk("busy_ignore_writes", 16'(wr_log.size()), 16'd1);
        chk("busy_ignore_w0", wlog(0), 16'h155);
        chk("busy_ignore_done", 16'(n_odn - base), 16'd1);

        // Rerun init while initialized: cascade mode with ICW3, no ICW4
        do_init(8'h10, 8'h40, 8'h04, 8'h99);
        chk("init2_nwrites", 16'(wr_log.size()), 16'd3);
        chk("init2_w0", wlog(0), 16'h010);
        chk("init2_w1", wlog(1), 16'h140);
        chk("init2_w2", wlog(2), 16'h104);
        chk("init2_initialized", {15'd0, initialized}, 16'd1);

        // Reset during the ICW2 write strobe
        begin
            int n;
            base = n_idn;
            clear_logs();
            @(negedge clk); icw1 = 8'h13; icw2 = 8'h20; icw4 = 8'h01; init_start = 1'b1;
            @(negedge clk); init_start = 1'b0;
            n = 0;
            while (wr_log.size() < 2 && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk("abort_reached_icw2", 16'(wr_log.size()), 16'd2);
            chk("abort_in_strobe", {15'd0, WR_n}, 16'd0);
            rst = 1'b1;
            @(negedge clk);
            chk("abort_wr_n", {15'd0, WR_n}, 16'd1);
            chk("abort_cs_n", {15'd0, CS_n}, 16'd1);
            rst = 1'b0;
            repeat (30) @(negedge clk);
            chk("abort_no_done", 16'(n_idn - base), 16'd0);
            chk("abort_initialized", {15'd0, initialized}, 16'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #100000;
        failures++;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pic_bus_master.md
PIC_BUS_MASTER -- requirements
Module: pic_bus_master

Interface
REQ-001 Parameter: WR_WIDTH, default 2, WR_n low time in clocks (>=1).
REQ-002 Parameter: RD_WIDTH, default 2, RD_n low time in clocks (>=1).
REQ-003 Parameter: RECOVERY, default 2, idle clocks between bus cycles (>=1).
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 init_start  in  1  pulse: run the ICW programming sequence.
REQ-007 icw1, icw2, icw3, icw4  in  8 each  ICW values, sampled on init_start acceptance.
REQ-008 ocw_req  in  1  pulse: issue one OCW write.
REQ-009 ocw_sel  in  2  00=OCW1, 01=OCW2, 10=OCW3; 11 reserved.
REQ-010 ocw_data  in  8  OCW value, sampled on ocw_req acceptance.
REQ-011 rd_req  in  1  pulse: read a PIC register.
REQ-012 rd_sel  in  2  00=IRR, 01=ISR, 10=IMR; 11 reserved.
REQ-013 CS_n, WR_n, RD_n  out  1 each  active-low bus strobes.
REQ-014 A0  out  1  bus address line.
REQ-015 cpu_data_out  out  8  write data; cpu_data_oe  out  1  drive enable.
REQ-016 cpu_data_in  in  8  bus read data.
REQ-017 busy  out  1  operation in progress; initialized  out  1  ICW sequence completed.
REQ-018 init_done, ocw_done, rd_valid, err  out  1 each  single-cycle pulses; rd_data  out  8.

Function
REQ-019 Bus FSM states SHALL be: IDLE, W_SETUP, W_STROBE, W_HOLD, R_SETUP, R_STROBE, R_HOLD, RECOVER.
REQ-020 Write cycle: W_SETUP 1 clk (CS_n=0, A0/data valid, oe=1, WR_n=1); W_STROBE WR_WIDTH clks (WR_n=0); W_HOLD 1 clk (WR_n=1, CS_n=0, data held); RECOVER RECOVERY clks (CS_n=1, oe=0).
REQ-021 Read cycle: R_SETUP 1 clk (CS_n=0, oe=0); R_STROBE RD_WIDTH clks (RD_n=0); rd_data captured from cpu_data_in on last R_STROBE clk; R_HOLD 1 clk; RECOVER.
REQ-022 WR_n and RD_n SHALL never be low simultaneously; cpu_data_oe SHALL be 0 whenever RD_n=0.
REQ-023 Init sequence: ICW1 (A0=0, bit4 forced 1), ICW2 (A0=1), ICW3 (A0=1) only if icw1[1]=0, ICW4 (A0=1) only if icw1[0]=1, back-to-back cycles.
REQ-024 After last ICW RECOVER: init_done pulses 1 clk, initialized=1, busy=0 next clock.
REQ-025 OCW write: OCW1 A0=1; OCW2 A0=0 with bits4:3 forced 00; OCW3 A0=0 with bits4:3 forced 01; ocw_done pulses after RECOVER.
REQ-026 Read IRR/ISR: OCW3 write 0x0A (IRR) or 0x0B (ISR), then read cycle A0=0; IMR: single read cycle A0=1; rd_valid pulses after RECOVER with rd_data stable until next read.
REQ-027 Requests accepted only in IDLE with busy=0; busy rises the clock after acceptance; requests while busy SHALL be ignored, no queueing.
REQ-028 Simultaneous requests: priority init_start > ocw_req > rd_req; lower ones dropped.
REQ-029 ocw_req or rd_req with initialized=0, ocw_sel=11 or rd_sel=11: no bus activity, err pulses 1 clk.
REQ-030 init_start while initialized=1 SHALL rerun the sequence; initialized clears on acceptance.

Reset
REQ-031 rst=1: state IDLE, CS_n=WR_n=RD_n=1, A0=0, cpu_data_out=0, oe=0, busy=0, initialized=0, rd_data=0, all pulses 0.
REQ-032 rst mid-cycle SHALL deassert all strobes on the next edge; the aborted operation produces no done/valid pulse.

Verification
REQ-033 icw1=0x13, icw2=0x20, icw4=0x01 -> writes 0x13@A0=0, 0x20@A0=1, 0x01@A0=1, no ICW3; init_done 18 clks after acceptance (defaults).
REQ-034 icw1=0x10, icw2=0x40, icw3=0x04 -> writes 0x10, 0x40, 0x04, no ICW4; initialized=1.
REQ-035 rd_req rd_sel=00, cpu_data_in=0x5A during RD_n low -> OCW3 0x0A write, read at A0=0, rd_valid with rd_data=0x5A.
REQ-036 ocw_req before init -> err pulse, CS_n stays 1; ocw_req and rd_req same clock -> only OCW issued.
REQ-037 rst asserted during W_STROBE of ICW2 -> WR_n=1 next clock, no init_done, initialized=0.
